sr_latch_bank_ctrl: RTL

//  Sequencer for a bank of WIDE cross-coupled NAND set/reset latches with active-low preset/clear.

---
 rtl/sr_latch_bank_pkg.sv | 30 +++
 rtl/srbank_cycle_timer.sv | 30 +++
 rtl/sr_latch_bank_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sr_latch_bank_pkg.sv
// Shared types and sizing helpers for the SR latch bank sequencer.
package sr_latch_bank_pkg;

    typedef enum logic {
        OP_CLEAR = 1'b0,
        OP_SET   = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PULSE,
        SETTLE,
        CHECK,
        REJECT
    } state_e;

    // Width needed for a counter holding max(pulse, settle, wide).
    function automatic int cnt_width(input int pulse_cyc, input int settle_cyc, input int wide);
        int m;
        m = pulse_cyc;
        if (settle_cyc > m) m = settle_cyc;
        if (wide > m) m = wide;
        return $clog2(m + 1);
    endfunction

    // Counter width for the default configuration (PULSE 2, SETTLE 3, WIDE 18).
    localparam int SRB_CNT_W = cnt_width(2, 3, 18);

endpackage

// File: rtl/srbank_cycle_timer.sv
// Loadable down-counter with a zero flag; times PULSE, SETTLE and INIT phases.
module srbank_cycle_timer
    import sr_latch_bank_pkg::*;
#(
    parameter int CNT_W = SRB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority; otherwise count down and park at zero.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Sequencer for a bank of NAND set/reset latches with active-low preset/clear.
// Optional feature: define SR_LATCH_BANK_AUTO_INIT_EN to clear the whole bank
// after reset release before accepting commands.
module sr_latch_bank_ctrl
    import sr_latch_bank_pkg::*;
#(
    parameter int WIDE       = 18,
    parameter int IDX_W      = 5,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_op_i,
    input  logic [IDX_W-1:0] cmd_idx_i,
    output logic [WIDE-1:0]  lat_preset_n_o,
    output logic [WIDE-1:0]  lat_clear_n_o,
    input  logic [WIDE-1:0]  lat_q_i,
    output logic             rsp_valid_o,
    output logic             rsp_err_o,
    output logic [IDX_W-1:0] rsp_idx_o
);

`ifdef SR_LATCH_BANK_AUTO_INIT_EN
    localparam bit AUTO_INIT = 1'b1;
`else
    localparam bit AUTO_INIT = 1'b0;
`endif

    localparam int               CNT_W       = cnt_width(PULSE_CYC, SETTLE_CYC, WIDE);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W:0]   WIDE_CMP    = (IDX_W + 1)'(WIDE);
    localparam state_e           RST_STATE   = AUTO_INIT ? INIT : IDLE;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_q, init_d;
    logic [WIDE-1:0]  preset_n_q, preset_n_d;
    logic [WIDE-1:0]  clear_n_q, clear_n_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    logic             transfer;
    logic             cmd_idx_ok;
    logic [WIDE-1:0]  cmd_mask;
    logic [WIDE-1:0]  idx_mask;

    assign transfer   = cmd_valid_i & cmd_ready_q;
    assign cmd_idx_ok = ({1'b0, cmd_idx_i} < WIDE_CMP);
    // A single-bit mask keeps the preset/clear lines one-hot-low by construction.
    assign cmd_mask   = WIDE'(1) << cmd_idx_i;
    assign idx_mask   = WIDE'(1) << idx_q;

    srbank_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state and next-output logic; line outputs are idle-high unless a phase drives them.
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        init_d      = init_q;
        preset_n_d  = '1;
        clear_n_d   = '1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = PULSE_LOAD;

        case (state_q)
            INIT: begin
                // Clear the whole bank, reusing PULSE/SETTLE timing with init_q set.
                state_d   = PULSE;
                clear_n_d = '0;
                tmr_load  = 1'b1;
            end
            IDLE: begin
                if (transfer) begin
                    op_d  = op_e'(cmd_op_i);
                    idx_d = cmd_idx_i;
                    if (!cmd_idx_ok) begin
                        state_d     = REJECT;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = PULSE;
                        tmr_load = 1'b1;
                        if (op_e'(cmd_op_i) == OP_SET) preset_n_d = ~cmd_mask;
                        else                           clear_n_d  = ~cmd_mask;
                    end
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end else if (init_q) begin
                    clear_n_d = '0;
                end else if (op_q == OP_SET) begin
                    preset_n_d = ~idx_mask;
                end else begin
                    clear_n_d = ~idx_mask;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    if (init_q) begin
                        state_d = IDLE;
                        init_d  = 1'b0;
                    end else begin
                        state_d     = CHECK;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = (lat_q_i[idx_q] != (op_q == OP_SET));
                    end
                end
            end
            CHECK:   state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_d = (state_d == IDLE);

    // State and registered outputs; reset releases every latch line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            op_q        <= OP_CLEAR;
            idx_q       <= '0;
            init_q      <= AUTO_INIT;
            preset_n_q  <= '1;
            clear_n_q   <= '1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= !AUTO_INIT;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            init_q      <= init_d;
            preset_n_q  <= preset_n_d;
            clear_n_q   <= clear_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign lat_preset_n_o = preset_n_q;
    assign lat_clear_n_o  = clear_n_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_idx_o      = idx_q;

endmodule
